// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, register names,
// FSM state encoding and instruction-register field positions.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH_HI = 2'd0,
    ST_FETCH_LO = 2'd1,
    ST_EXECUTE  = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Source of the register write-back value
  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_IMM  = 2'd1,
    WSEL_RF1  = 2'd2,
    WSEL_ALU  = 2'd3
  } wsel_t;

  localparam logic [3:0] OPC_NOP      = 4'd0;
  localparam logic [3:0] OPC_LDI      = 4'd1;
  localparam logic [3:0] OPC_MOV      = 4'd2;
  localparam logic [3:0] OPC_JMP      = 4'd3;
  localparam logic [3:0] OPC_JZ       = 4'd4;
  localparam logic [3:0] OPC_HALT     = 4'd5;
  localparam logic [3:0] OPC_ALU_BASE = 4'd8;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_X  = 3'd1;
  localparam logic [2:0] REG_Y  = 3'd2;
  localparam logic [2:0] REG_Z  = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_FP = 3'd5;

  // Registers above this index are read-only; writes to them are dropped
  localparam logic [2:0] REG_WRITABLE_MAX = REG_FP;

  localparam int IR_OPC_MSB = 15;
  localparam int IR_OPC_LSB = 12;
  localparam int IR_RD_MSB  = 11;
  localparam int IR_RD_LSB  = 9;
  localparam int IR_RS1_MSB = 7;
  localparam int IR_RS1_LSB = 5;
  localparam int IR_RS2_MSB = 4;
  localparam int IR_RS2_LSB = 2;
  localparam int IR_IMM_MSB = 7;
  localparam int IR_IMM_LSB = 0;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Purely combinational instruction decode: splits the 16-bit IR into fields
// and classifies the opcode.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [7:0]  imm,
  output logic [2:0]  alu_op,
  output wsel_t       wsel,
  output logic        is_jump,
  output logic        is_cond,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [3:0] opc;
  logic       unused_ir8;

  assign opc        = ir[IR_OPC_MSB:IR_OPC_LSB];
  assign rd         = ir[IR_RD_MSB:IR_RD_LSB];
  assign rs1        = ir[IR_RS1_MSB:IR_RS1_LSB];
  assign rs2        = ir[IR_RS2_MSB:IR_RS2_LSB];
  assign imm        = ir[IR_IMM_MSB:IR_IMM_LSB];
  assign alu_op     = opc[2:0];
  assign unused_ir8 = ir[8];

  always_comb begin
    wsel       = WSEL_NONE;
    is_jump    = 1'b0;
    is_cond    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (opc >= OPC_ALU_BASE) begin
      wsel = WSEL_ALU;
    end else begin
      case (opc)
        OPC_NOP:  ;
        OPC_LDI:  wsel = WSEL_IMM;
        OPC_MOV:  wsel = WSEL_RF1;
        OPC_JMP:  is_jump = 1'b1;
        OPC_JZ: begin
          is_jump = 1'b1;
          is_cond = 1'b1;
        end
        OPC_HALT: is_halt = 1'b1;
        default:  is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: two-byte fetch over an 8-bit memory
// handshake, one-cycle execute driving the register file and external ALU.
// Handshake: a fetch byte transfers on the rising edge where imem_req and
// imem_valid are both high; imem_valid is don't-care while imem_req is low.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic [7:0] imem_rdata,
  input  logic       imem_valid,
  output logic [2:0] reg_addr1,
  output logic [2:0] reg_addr2,
  input  logic [7:0] rf_data1,
  input  logic [7:0] rf_data2,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic [2:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_enable,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal,
  output logic [1:0] state_dbg
);

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;

  logic [2:0]  rd, rs1, rs2;
  logic [7:0]  imm;
  wsel_t       wsel;
  logic        is_jump, is_cond, is_halt, is_illegal;
  logic        take_jump;
  logic        unused_rf2;

  instr_decode u_decode (
    .ir         (ir),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .alu_op     (alu_op),
    .wsel       (wsel),
    .is_jump    (is_jump),
    .is_cond    (is_cond),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // JZ tests the register named by rd, so read port 1 is steered to it
  assign take_jump = is_jump && (!is_cond || (rf_data1 == 8'h00));
  assign unused_rf2 = ^rf_data2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH_HI;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_HI: begin
          if (imem_valid) begin
            ir[15:8] <= imem_rdata;
            pc       <= pc + 8'd1;
            state    <= ST_FETCH_LO;
          end
        end
        ST_FETCH_LO: begin
          if (imem_valid) begin
            ir[7:0] <= imem_rdata;
            pc      <= pc + 8'd1;
            state   <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_halt || is_illegal) begin
            state <= ST_HALT;
            if (is_illegal) illegal <= 1'b1;
          end else begin
            state <= ST_FETCH_HI;
            if (take_jump) pc <= imm;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // imem_req is gated by rst_n so it drops the moment reset is asserted
  assign imem_req     = rst_n && ((state == ST_FETCH_HI) || (state == ST_FETCH_LO));
  assign imem_addr    = pc;
  assign halted       = (state == ST_HALT);
  assign instr_done   = (state == ST_EXECUTE);
  assign state_dbg    = state;

  assign reg_addr1    = is_cond ? rd : rs1;
  assign reg_addr2    = rs2;
  assign write_addr   = rd;
  assign write_enable = instr_done && (wsel != WSEL_NONE) && (rd <= REG_WRITABLE_MAX);

  always_comb begin
    write_data = 8'h00;
    case (wsel)
      WSEL_IMM: write_data = imm;
      WSEL_RF1: write_data = rf_data1;
      WSEL_ALU: write_data = alu_result;
      default:  write_data = 8'h00;
    endcase
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller that sits directly upstream of the 8-bit register file and drives all of its ports: reg_addr1, reg_addr2, write_addr, write_data and write_enable.
- Fetches 2-byte instructions over an 8-bit instruction-memory handshake and decodes them.
- Sequences each register read, external-ALU operation and register write-back in a single EXECUTE cycle.
- Owns the program counter and handles jumps and halt.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_addr  output  8  byte address of the instruction memory; equals PC.
imem_req  output  1  fetch request; high in FETCH_HI and FETCH_LO.
imem_rdata  input  8  instruction byte; valid when imem_valid is high.
imem_valid  input  1  memory acknowledge; the byte is captured on the clk edge where imem_req and imem_valid are both high.
reg_addr1  output  3  register-file read port 1 address (rs1).
reg_addr2  output  3  register-file read port 2 address (rs2).
rf_data1  input  8  register-file out_1.
rf_data2  input  8  register-file out_2.
alu_op  output  3  operation select for the external ALU, whose operands are rf_data1 and rf_data2.
alu_result  input  8  external ALU result (combinational).
write_addr  output  3  register-file write address (rd).
write_data  output  8  register-file write data.
write_enable  output  1  register-file write strobe; the write lands on the next clk edge.
instr_done  output  1  one-cycle pulse in EXECUTE of every retired instruction.
halted  output  1  high in HALT state.
illegal  output  1  sticky; set when an undefined opcode is executed.

Behaviour:
- Reset: async assertion forces the following regardless of clock; after rst_n deasserts, the first cycle is FETCH_HI.
  - PC=RESET_PC, state=FETCH_HI, instruction register=0, illegal=0.
  - halted=0, imem_req=0 while rst_n is low.
  - write_enable=0 and instr_done=0 (both are decoded from the state).
- Reset mid-fetch or mid-execute: the in-flight instruction is abandoned and no write occurs.
- FSM: FETCH_HI -> FETCH_LO -> EXECUTE -> FETCH_HI, or HALT.
  - Each FETCH state holds, with imem_req high and imem_addr=PC, until imem_valid is high.
  - On the accepting edge: the byte is latched (IR[15:8], then IR[7:0]), PC<=PC+1 (8-bit wrap, FF->00), and the state advances.
  - A fetch that never completes is a legal stall.
- Instruction layout: byte0 = IR[15:8], byte1 = IR[7:0].
  - opc=IR[15:12], rd=IR[11:9], rs1=IR[7:5], rs2=IR[4:2], imm=IR[7:0].
- EXECUTE is exactly one cycle. All register-file and ALU outputs are combinational from IR and state.
  - reg_addr1=rs1, except JZ, which uses rd. reg_addr2=rs2. write_addr=rd. alu_op=opc[2:0].
  - Outside EXECUTE: write_enable=0; reg_addr and write_data hold their decode of IR.
- Opcodes:
  - 0 NOP: no write.
  - 1 LDI: rd<=imm.
  - 2 MOV: rd<=rf_data1.
  - 3 JMP: PC<=imm.
  - 4 JZ: if rf_data1==0 then PC<=imm, else PC unchanged.
  - 5 HALT: next state is HALT.
  - 6, 7: undefined; illegal<=1, next state is HALT, no write.
  - 8..15 ALU: rd<=alu_result, alu_op=opc[2:0].
- Writes to rd=6 or rd=7 suppress write_enable. The instruction still retires; this is not an error.
- Latency: 3 cycles per instruction with zero-wait memory; the write is visible to the next instruction's reads.
- HALT is terminal until reset: halted=1, imem_req=0, write_enable=0, instr_done=0.
- Jump target wins over PC increment. A jump to the current PC is allowed (tight loop).
- imem_valid is ignored when imem_req is low.

Decomposition:
- Shared package holds:
  - opcode localparams (OPC_NOP..OPC_HALT, OPC_ALU_BASE);
  - register index constants (REG_A=0, REG_X=1, REG_Y=2, REG_Z=3, REG_SP=4, REG_FP=5);
  - state encodings;
  - IR field bit positions.
- One natural sub-module: instr_decode, a purely combinational mapping from IR to rd, rs1, rs2, imm, write-select, is_jump, is_halt and is_illegal. The FSM, PC and handshake stay in the top.

Test Plan:
- Reset then zero-wait program "LDI X,0x5A" (bytes 0x12,0x5A) -> EXECUTE in cycle 3, write_enable=1, write_addr=1, write_data=0x5A, instr_done pulse, next imem_addr=0x02.
- Stall: hold imem_valid low 4 cycles in FETCH_LO -> imem_req stays high, imem_addr constant, no write; on release the instruction completes normally.
- ALU: X=0x03, Y=0x04, opcode 8, rd=A, rs1=X, rs2=Y -> alu_op=0, reg_addr1=1, reg_addr2=2, A<=alu_result (model add -> 0x07).
- JZ with A=0 and imm=0x10 -> next imem_addr=0x10. With A=0x01 -> next imem_addr=PC+2.
- PC wrap: RESET_PC=0xFE, NOP -> next fetch at 0x00. LDI with rd=7 -> write_enable stays 0 and instr_done pulses.
- Opcode 6 -> illegal=1, halted=1, imem_req=0 thereafter. Assert rst_n low during a later FETCH_LO -> all outputs return to reset values immediately.
